reg_file: RTL and testbench



---
 rtl/reg_file.sv | 83 ++++++++
 tb/tb_reg_file.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// rtl/reg_file.sv - eight-entry 8-bit register file with opcode-gated write-back
//
// Optional feature macro: REG_BYPASS_EN (same-cycle write-to-read forwarding).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   wb_data    in   [7:0] write-back value
//   opcode     in   [3:0] opcode of instruction in write-back
//   wb_addr    in   [2:0] destination register index
//   stall      in   suppress any write this cycle
//   ra_addr    in   [2:0] read port A index
//   rb_addr    in   [2:0] read port B index
//   ra_data    out  [7:0] contents of regs[ra_addr]
//   rb_data    out  [7:0] contents of regs[rb_addr]
//   acc        out  [7:0] contents of regs[0]
//   zero_flag  out  last committed wb_data was 8'h00 (registered)
//   wr_commit  out  a write commits at the next edge (combinational)
module reg_file (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wb_data,
  input  logic [3:0] opcode,
  input  logic [2:0] wb_addr,
  input  logic       stall,
  input  logic [2:0] ra_addr,
  input  logic [2:0] rb_addr,
  output logic [7:0] ra_data,
  output logic [7:0] rb_data,
  output logic [7:0] acc,
  output logic       zero_flag,
  output logic       wr_commit
);

  localparam logic [3:0] OP_LB   = 4'b0000;
  localparam logic [3:0] OP_LHB  = 4'b0001;
  localparam logic [3:0] OP_LIM  = 4'b0100;
  localparam logic [3:0] OP_MVB  = 4'b0101;
  localparam logic [3:0] OP_MVF  = 4'b0110;
  localparam logic [3:0] OP_ADD  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SFT  = 4'b1001;
  localparam logic [3:0] OP_INC  = 4'b1101;

  logic [7:0] regs [8];
  logic       writing_opcode;

  always_comb begin
    writing_opcode = 1'b0;
    case (opcode)
      OP_LB, OP_LHB, OP_LIM, OP_MVB, OP_MVF,
      OP_ADD, OP_SUB, OP_SFT, OP_INC: writing_opcode = 1'b1;
      default:                        writing_opcode = 1'b0;
    endcase
  end

  // Reset is folded in so a colliding write is never reported as committing.
  assign wr_commit = writing_opcode & ~stall & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 8'h00;
      end
      zero_flag <= 1'b0;
    end else if (wr_commit) begin
      regs[wb_addr] <= wb_data;
      zero_flag     <= (wb_data == 8'h00);
    end
  end

`ifdef REG_BYPASS_EN
  // Forward the committing value so a same-cycle read sees the new data.
  assign ra_data = (wr_commit && (ra_addr == wb_addr)) ? wb_data : regs[ra_addr];
  assign rb_data = (wr_commit && (rb_addr == wb_addr)) ? wb_data : regs[rb_addr];
  assign acc     = (wr_commit && (wb_addr == 3'd0))    ? wb_data : regs[0];
`else
  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];
  assign acc     = regs[0];
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard testbench for reg_file
module tb_reg_file;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wb_data;
  logic [3:0] opcode;
  logic [2:0] wb_addr;
  logic       stall;
  logic [2:0] ra_addr;
  logic [2:0] rb_addr;
  logic [7:0] ra_data;
  logic [7:0] rb_data;
  logic [7:0] acc;
  logic       zero_flag;
  logic       wr_commit;

  reg_file dut (
    .clk       (clk),
    .reset     (reset),
    .wb_data   (wb_data),
    .opcode    (opcode),
    .wb_addr   (wb_addr),
    .stall     (stall),
    .ra_addr   (ra_addr),
    .rb_addr   (rb_addr),
    .ra_data   (ra_data),
    .rb_data   (rb_data),
    .acc       (acc),
    .zero_flag (zero_flag),
    .wr_commit (wr_commit)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] LB = 4'b0000, LHB = 4'b0001, JMP = 4'b0010, STR = 4'b0011;
  localparam logic [3:0] LIM = 4'b0100, MVB = 4'b0101, MVF = 4'b0110, ADD = 4'b0111;
  localparam logic [3:0] SUB = 4'b1000, SFT = 4'b1001, BNE = 4'b1010, BEQ = 4'b1011;
  localparam logic [3:0] BLT = 4'b1100, INC = 4'b1101, HALT = 4'b1110, TBA = 4'b1111;

  typedef struct {
    string      tag;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] acc;
    logic       zf;
    logic       wc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [8];
  logic       model_zf;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic is_writing(input logic [3:0] op);
    return op inside {LB, LHB, LIM, MVB, MVF, ADD, SUB, SFT, INC};
  endfunction

  // Called at the falling edge: drive, predict, compare, then advance the model at the rising edge.
  task automatic step(input string tag, input logic [3:0] op, input logic [2:0] wa,
                      input logic [7:0] wd, input logic st, input logic rst,
                      input logic [2:0] a, input logic [2:0] b);
    exp_t e;
    exp_t got;
    logic wc;
    opcode  = op;
    wb_addr = wa;
    wb_data = wd;
    stall   = st;
    reset   = rst;
    ra_addr = a;
    rb_addr = b;
    wc = is_writing(op) && !st && !rst;
    e.tag = tag;
    e.ra  = model[a];
    e.rb  = model[b];
    e.acc = model[0];
`ifdef REG_BYPASS_EN
    if (wc && a == wa) e.ra = wd;
    if (wc && b == wa) e.rb = wd;
    if (wc && wa == 3'd0) e.acc = wd;
`endif
    e.zf = model_zf;
    e.wc = wc;
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    check({got.tag, ".ra"},  ra_data, got.ra);
    check({got.tag, ".rb"},  rb_data, got.rb);
    check({got.tag, ".acc"}, acc, got.acc);
    check({got.tag, ".zf"},  {7'd0, zero_flag}, {7'd0, got.zf});
    check({got.tag, ".wc"},  {7'd0, wr_commit}, {7'd0, got.wc});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      model_zf = 1'b0;
    end else if (wc) begin
      model[wa] = wd;
      model_zf  = (wd == 8'h00);
    end
    @(negedge clk);
  endtask

  // Idle read with a non-writing opcode, for spot checks against literal values.
  task automatic peek(input logic [2:0] a, input logic [2:0] b);
    opcode  = JMP;
    wb_addr = 3'd0;
    wb_data = 8'hxx;
    stall   = 1'b0;
    reset   = 1'b0;
    ra_addr = a;
    rb_addr = b;
    #1;
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] wd;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    model_zf = 1'b0;
    reset = 1'b1; opcode = JMP; wb_addr = 3'd0; wb_data = 8'h00; stall = 1'b0;
    ra_addr = 3'd0; rb_addr = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset after preload
    step("pre_r3",   LIM,  3'd3, 8'h5A, 1'b0, 1'b0, 3'd3, 3'd0);
    step("rd_r3",    HALT, 3'd0, 8'hxx, 1'b0, 1'b0, 3'd3, 3'd3);
    step("rst",      ADD,  3'd3, 8'h12, 1'b0, 1'b1, 3'd3, 3'd0);
    peek(3'd3, 3'd0);
    check("rst_r3", ra_data, 8'h00);
    check("rst_acc", acc, 8'h00);
    check("rst_zf", {7'd0, zero_flag}, 8'h00);

    // Write/read
    step("add_r5",   ADD,  3'd5, 8'hC3, 1'b0, 1'b0, 3'd1, 3'd2);
    step("rd_r5",    JMP,  3'd0, 8'hxx, 1'b0, 1'b0, 3'd5, 3'd5);
    peek(3'd5, 3'd5);
    check("r5_const", ra_data, 8'hC3);

    // Non-writing filter
    step("lb_r2",    LB,   3'd2, 8'h11, 1'b0, 1'b0, 3'd2, 3'd0);
    step("beq_r2",   BEQ,  3'd2, 8'hxx, 1'b0, 1'b0, 3'd2, 3'd2);
    step("str_r2",   STR,  3'd2, 8'hxx, 1'b0, 1'b0, 3'd2, 3'd5);
    step("halt_r2",  HALT, 3'd2, 8'hxx, 1'b0, 1'b0, 3'd2, 3'd2);
    peek(3'd2, 3'd2);
    check("r2_hold", ra_data, 8'h11);
    check("zf_hold", {7'd0, zero_flag}, 8'h00);

    // Stall and flag
    step("sub_stall", SUB, 3'd1, 8'h00, 1'b1, 1'b0, 3'd1, 3'd1);
    step("sub_go",    SUB, 3'd1, 8'h00, 1'b0, 1'b0, 3'd1, 3'd1);
    peek(3'd1, 3'd1);
    check("r1_zero", ra_data, 8'h00);
    check("zf_set", {7'd0, zero_flag}, 8'h01);
    step("lim_r4",    LIM, 3'd4, 8'h07, 1'b0, 1'b0, 3'd4, 3'd1);
    peek(3'd4, 3'd4);
    check("zf_clr", {7'd0, zero_flag}, 8'h00);

    // Read during write on register 0
    step("lb_r0",    LB,   3'd0, 8'h10, 1'b0, 1'b0, 3'd0, 3'd0);
    step("rdw_r0",   LB,   3'd0, 8'h99, 1'b0, 1'b0, 3'd0, 3'd0);
    peek(3'd0, 3'd0);
    check("r0_after", rb_data, 8'h99);
    check("acc_after", acc, 8'h99);

    // Reset colliding with a write
    step("inc_r7_rst", INC, 3'd7, 8'hFF, 1'b0, 1'b1, 3'd7, 3'd0);
    peek(3'd7, 3'd0);
    check("r7_rst", ra_data, 8'h00);
    check("zf_rst", {7'd0, zero_flag}, 8'h00);

    // Random mix of opcodes, stalls and occasional reset
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      wd = is_writing(op) ? 8'($urandom_range(0, 255)) : 8'hxx;
      if ($urandom_range(0, 3) == 0) wd = 8'h00;
      step("rand", op, 3'($urandom_range(0, 7)), wd,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_left got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
